// File: rtl/video_pkg.sv
// Shared timing defaults, pattern encodings and bar colours for the HDMI
// video timing / test-pattern generator. Colours are packed {B,G,R}.
package video_pkg;

  localparam int CNT_W = 11;

  // 640x480@60 with a 25.175 MHz pixel clock
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_SOLID = 2'd3
  } pattern_t;

  typedef struct packed {
    pattern_t    sel;
    logic [23:0] solid;
  } pattern_cfg_t;

  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'h00FFFF;
  localparam logic [23:0] COL_CYAN    = 24'hFFFF00;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_RED     = 24'h0000FF;
  localparam logic [23:0] COL_BLUE    = 24'hFF0000;
  localparam logic [23:0] COL_BLACK   = 24'h000000;

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return COL_WHITE;
      3'd1:    return COL_YELLOW;
      3'd2:    return COL_CYAN;
      3'd3:    return COL_GREEN;
      3'd4:    return COL_MAGENTA;
      3'd5:    return COL_RED;
      3'd6:    return COL_BLUE;
      default: return COL_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_gen.sv
// Next-pixel colour for the selected test pattern. Combinational apart from
// the colour-bar position counter, which avoids dividing x by the bar width.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE
) (
  input  logic         hdmi_clk,
  input  logic         reset,
  input  logic [7:0]   x,
  input  logic [7:0]   y,
  input  logic         de,
  input  logic         line_start,
  input  pattern_cfg_t pattern,
  output logic [23:0]  rgb_next
);

  localparam logic [CNT_W-1:0] BW_LAST = CNT_W'(H_ACTIVE / 8 - 1);

  logic [CNT_W-1:0] bar_cnt, cur_cnt;
  logic [2:0]       bar_idx, cur_idx;

  // The registered count describes the previous pixel; line_start forces bar 0.
  assign cur_cnt = line_start ? '0 : bar_cnt;
  assign cur_idx = line_start ? '0 : bar_idx;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      bar_cnt <= '0;
      bar_idx <= '0;
    end else if (de) begin
      if (cur_cnt == BW_LAST) begin
        bar_cnt <= '0;
        bar_idx <= cur_idx + 3'd1;
      end else begin
        bar_cnt <= cur_cnt + 1'b1;
        bar_idx <= cur_idx;
      end
    end
  end

  // NOTE: the default assignment on entry keeps this block free of latches
  // on every path through the case.
  always_comb begin
    rgb_next = COL_BLACK;
    if (de) begin
      case (pattern.sel)
        PAT_BARS:  rgb_next = bar_colour(cur_idx);
        PAT_CHECK: rgb_next = (x[5] ^ y[5]) ? COL_BLACK : COL_WHITE;
        PAT_GRAD:  rgb_next = {x ^ y, y, x};
        default:   rgb_next = pattern.solid;
      endcase
    end
  end

endmodule

// File: rtl/video_timing_pattern_gen.sv
// Raster timing plus test-pattern pixel source for the HDMI output stage.
// All outputs are registered once and aligned to the same counter state.
module video_timing_pattern_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FRONT  = DEF_H_FRONT,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BACK   = DEF_H_BACK,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FRONT  = DEF_V_FRONT,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BACK   = DEF_V_BACK,
  parameter logic H_POL    = 1'b0,
  parameter logic V_POL    = 1'b0
) (
  input  logic             hdmi_clk,
  input  logic             reset,
  input  logic [1:0]       pattern_sel,
  input  logic [23:0]      solid_rgb,
  output logic [2:0]       hve_sync,
  output logic [23:0]      rgb,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             line_start, frame_origin;
  logic             de_c, hs_c, vs_c;
  pattern_cfg_t     pat_q, pat_eff;
  logic [23:0]      rgb_next;

  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign line_start   = (h_cnt == '0);
  assign frame_origin = line_start && (v_cnt == '0);
  assign de_c         = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_c         = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_c         = (v_cnt >= VS_START) && (v_cnt < VS_END);

  // Pixel (0,0) already uses the freshly captured pattern, so a frame is never mixed.
  always_comb begin
    pat_eff = pat_q;
    if (frame_origin) begin
      pat_eff.sel   = pattern_t'(pattern_sel);
      pat_eff.solid = solid_rgb;
    end
  end

  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      pat_q <= '{sel: PAT_BARS, solid: COL_BLACK};
    end else if (frame_origin) begin
      pat_q <= pat_eff;
    end
  end

  video_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_pattern (
    .hdmi_clk   (hdmi_clk),
    .reset      (reset),
    .x          (h_cnt[7:0]),
    .y          (v_cnt[7:0]),
    .de         (de_c),
    .line_start (line_start),
    .pattern    (pat_eff),
    .rgb_next   (rgb_next)
  );

  always_ff @(posedge hdmi_clk or posedge reset) begin
    if (reset) begin
      hve_sync    <= {1'b0, ~V_POL, ~H_POL};
      rgb         <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      hve_sync    <= {de_c, vs_c ? V_POL : ~V_POL, hs_c ? H_POL : ~H_POL};
      rgb         <= rgb_next;
      pix_x       <= de_c ? h_cnt : '0;
      pix_y       <= de_c ? v_cnt : '0;
      frame_start <= de_c && frame_origin;
    end
  end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Scoreboard bench: expected pixels are queued by output cycle number and a
// monitor compares them on the falling edge. Uses a shrunken raster (288x46).
module tb_video_timing_pattern_gen;

  localparam int HA = 256, HF = 8, HS = 16, HB = 8;
  localparam int VA = 40,  VF = 2, VS = 2,  VB = 2;
  localparam int HT = HA + HF + HS + HB;   // 288
  localparam int VT = VA + VF + VS + VB;   // 46
  localparam int FT = HT * VT;             // 13248
  localparam int RST_CYC = -1;

  logic        hdmi_clk;
  logic        reset;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_rgb;
  logic [2:0]  hve_sync;
  logic [23:0] rgb;
  logic [10:0] pix_x, pix_y;
  logic        frame_start;

  video_timing_pattern_gen #(
    .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
    .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
    .H_POL (1'b0), .V_POL (1'b0)
  ) dut (
    .hdmi_clk    (hdmi_clk),
    .reset       (reset),
    .pattern_sel (pattern_sel),
    .solid_rgb   (solid_rgb),
    .hve_sync    (hve_sync),
    .rgb         (rgb),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .frame_start (frame_start)
  );

  initial hdmi_clk = 1'b0;
  always #5 hdmi_clk = ~hdmi_clk;

  typedef struct {
    int          cyc;
    string       name;
    logic [2:0]  hve;
    logic [23:0] rgb;
    logic [10:0] px;
    logic [10:0] py;
    logic        fs;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   out_cyc = RST_CYC;

  // Index of the counter state currently shown on the outputs.
  always @(posedge hdmi_clk) out_cyc = reset ? RST_CYC : out_cyc + 1;

  function automatic int at(input int f, input int v, input int h);
    return f * FT + v * HT + h;
  endfunction

  task automatic push(input int cyc, input string name, input logic [2:0] hve,
                      input logic [23:0] col, input int px, input int py, input logic fs);
    exp_t e;
    e.cyc = cyc; e.name = name; e.hve = hve; e.rgb = col;
    e.px = 11'(px); e.py = 11'(py); e.fs = fs;
    sb.push_back(e);
  endtask

  task automatic compare(input exp_t e);
    checks++;
    if ({hve_sync, rgb, pix_x, pix_y, frame_start} !== {e.hve, e.rgb, e.px, e.py, e.fs}) begin
      errors++;
      $display("FAIL %s cyc=%0d got hve=%b rgb=%h x=%0d y=%0d fs=%b want hve=%b rgb=%h x=%0d y=%0d fs=%b",
               e.name, e.cyc, hve_sync, rgb, pix_x, pix_y, frame_start,
               e.hve, e.rgb, e.px, e.py, e.fs);
    end
  endtask

  always @(negedge hdmi_clk) begin
    if (!reset && !hve_sync[2]) begin
      checks++;
      if (rgb !== 24'h0) begin
        errors++;
        $display("FAIL blank_rgb cyc=%0d got rgb=%h want 000000", out_cyc, rgb);
      end
    end
    if (sb.size() > 0) begin
      if (reset) begin
        if (sb[0].cyc == RST_CYC) compare(sb.pop_front());
      end else if (sb[0].cyc == out_cyc) begin
        compare(sb.pop_front());
      end else if (sb[0].cyc != RST_CYC && sb[0].cyc < out_cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL %s missed cyc=%0d now=%0d", e.name, e.cyc, out_cyc);
      end
    end
  end

  task automatic wait_out(input int target);
    while (out_cyc < target) begin
      @(posedge hdmi_clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog out_cyc=%0d", out_cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    reset = 1'b1;
    pattern_sel = 2'd0;
    solid_rgb = 24'h0;
    for (int i = 0; i < 3; i++) push(RST_CYC, "reset_hold", 3'b011, 24'h0, 0, 0, 1'b0);
    repeat (5) @(posedge hdmi_clk);
    #1;
    push(0, "first_pix",  3'b111, 24'hFFFFFF, 0, 0, 1'b1);
    push(1, "second_pix", 3'b111, 24'hFFFFFF, 1, 0, 1'b0);
    reset = 1'b0;

    // Asynchronous reset in the middle of a line: outputs clear before the next edge.
    wait_out(300);
    for (int i = 0; i < 3; i++) push(RST_CYC, "reset_mid", 3'b011, 24'h0, 0, 0, 1'b0);
    #2 reset = 1'b1;
    repeat (4) @(posedge hdmi_clk);
    #1;

    push(at(0, 0, 0),    "bars_x0",      3'b111, 24'hFFFFFF, 0,   0,  1'b1);
    push(at(0, 0, 31),   "bars_x31",     3'b111, 24'hFFFFFF, 31,  0,  1'b0);
    push(at(0, 0, 32),   "bars_x32",     3'b111, 24'h00FFFF, 32,  0,  1'b0);
    push(at(0, 0, 96),   "bars_green",   3'b111, 24'h00FF00, 96,  0,  1'b0);
    push(at(0, 0, 160),  "bars_red",     3'b111, 24'h0000FF, 160, 0,  1'b0);
    push(at(0, 0, 223),  "bars_blue",    3'b111, 24'hFF0000, 223, 0,  1'b0);
    push(at(0, 0, 224),  "bars_black",   3'b111, 24'h000000, 224, 0,  1'b0);
    push(at(0, 0, 255),  "bars_last",    3'b111, 24'h000000, 255, 0,  1'b0);
    push(at(0, 0, 256),  "h_front",      3'b011, 24'h0,      0,   0,  1'b0);
    push(at(0, 0, 263),  "h_pre_sync",   3'b011, 24'h0,      0,   0,  1'b0);
    push(at(0, 0, 264),  "hsync_start",  3'b010, 24'h0,      0,   0,  1'b0);
    push(at(0, 0, 279),  "hsync_end",    3'b010, 24'h0,      0,   0,  1'b0);
    push(at(0, 0, 280),  "h_back",       3'b011, 24'h0,      0,   0,  1'b0);
    push(at(0, 1, 0),    "line1_x0",     3'b111, 24'hFFFFFF, 0,   1,  1'b0);
    push(at(0, 1, 32),   "line1_x32",    3'b111, 24'h00FFFF, 32,  1,  1'b0);
    push(at(0, 25, 0),   "bars_kept",    3'b111, 24'hFFFFFF, 0,   25, 1'b0);
    push(at(0, 41, 0),   "v_front",      3'b011, 24'h0,      0,   0,  1'b0);
    push(at(0, 42, 0),   "vsync_start",  3'b001, 24'h0,      0,   0,  1'b0);
    push(at(0, 42, 270), "vsync_hsync",  3'b000, 24'h0,      0,   0,  1'b0);
    push(at(0, 43, 287), "vsync_end",    3'b001, 24'h0,      0,   0,  1'b0);
    push(at(0, 44, 0),   "v_back",       3'b011, 24'h0,      0,   0,  1'b0);
    push(at(0, 45, 287), "frame_last",   3'b011, 24'h0,      0,   0,  1'b0);
    push(at(1, 0, 0),    "solid_origin", 3'b111, 24'h123456, 0,   0,  1'b1);
    push(at(1, 20, 256), "solid_blank",  3'b011, 24'h0,      0,   0,  1'b0);
    push(at(1, 30, 10),  "solid_kept",   3'b111, 24'h123456, 10,  30, 1'b0);
    push(at(1, 39, 255), "solid_last",   3'b111, 24'h123456, 255, 39, 1'b0);
    push(at(2, 0, 0),    "grad_origin",  3'b111, 24'h000000, 0,   0,  1'b1);
    push(at(2, 5, 3),    "grad_5_3",     3'b111, 24'h060503, 3,   5,  1'b0);
    push(at(2, 37, 200), "grad_37_200",  3'b111, 24'hED25C8, 200, 37, 1'b0);
    push(at(2, 39, 255), "grad_last",    3'b111, 24'hD827FF, 255, 39, 1'b0);
    push(at(3, 0, 0),    "check_origin", 3'b111, 24'hFFFFFF, 0,   0,  1'b1);
    push(at(3, 0, 31),   "check_0_31",   3'b111, 24'hFFFFFF, 31,  0,  1'b0);
    push(at(3, 0, 32),   "check_0_32",   3'b111, 24'h000000, 32,  0,  1'b0);
    push(at(3, 32, 0),   "check_32_0",   3'b111, 24'h000000, 0,   32, 1'b0);
    push(at(3, 32, 32),  "check_32_32",  3'b111, 24'hFFFFFF, 32,  32, 1'b0);
    reset = 1'b0;

    // Pattern changes mid-frame must only show from the following frame.
    wait_out(at(0, 20, 0));
    pattern_sel = 2'd3;
    solid_rgb   = 24'h123456;
    wait_out(at(1, 20, 0));
    pattern_sel = 2'd2;
    solid_rgb   = 24'h654321;
    wait_out(at(2, 20, 0));
    pattern_sel = 2'd1;
    wait_out(at(3, 32, 32) + 4);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never_seen cyc=%0d", e.name, e.cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
